// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: one-outstanding req/ack fetcher feeding a small {pc, instr} prefetch FIFO.
// Define FETCH_PERF_CNT_EN to add the stall_cnt_o / fetch_cnt_o performance counters.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] fetch_cnt_o
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     drain_addr_q, drain_addr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]     pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic            push, pop;

    assign instr_valid_o = (count_q != '0);
    // Flush wins over both FIFO operations: the head is not consumed and returned data is dropped.
    assign pop  = instr_valid_o && instr_ready_i && !flush_i;
    assign push = (state_q == StReq) && imem_ack_i && !flush_i;

    always_comb begin
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        if (flush_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
        end
        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i && (count_d < DepthCnt)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (flush_i) begin
                    // An unacked request must still complete; remember its address for the drain.
                    state_d      = imem_ack_i ? StIdle : StDrain;
                    drain_addr_d = fetch_pc_q;
                end else if (imem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (start_i && (count_d < DepthCnt)) ? StReq : StIdle;
                end
            end
            StDrain: begin
                if (imem_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            if (flush_i) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_data_i;
        end
    end

    assign imem_req_o  = (state_q != StIdle);
    assign imem_addr_o = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
    assign instr_o     = instr_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign pc_o        = instr_valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, fetch_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            if (!instr_valid_o && start_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (push && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fetch_cnt_o = fetch_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

    // Credit check at issue time must make an overflowing push impossible.
    assert property (@(posedge clk_i) disable iff (!rst_i) push |-> (count_q < DepthCnt));

    // Memory protocol: request and address hold until acknowledged.
    assert property (@(posedge clk_i) disable iff (!rst_i)
        (imem_req_o && !imem_ack_i) |=> (imem_req_o && $stable(imem_addr_o)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: directed scenarios push expected {pc, instr} pairs,
// a negedge monitor pops and compares every accepted FIFO head.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] fetch_cnt_o;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    int          lat = 0;
    int          wait_cnt = 0;
    int unsigned stall_model = 0;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .flush_i      (flush_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .instr_ready_i(instr_ready_i)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .fetch_cnt_o  (fetch_cnt_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: acks after `lat` idle request cycles per address; data = addr ^ A5A5_0000.
    always begin
        @(posedge clk or negedge rst_i);
        if (!rst_i) begin
            imem_ack_i = 1'b0;
            wait_cnt   = 0;
        end else begin
            #1;
            if (imem_req_o && rst_i) begin
                if (wait_cnt >= lat) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = imem_addr_o ^ 32'hA5A5_0000;
                    wait_cnt    = 0;
                end else begin
                    imem_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack_i = 1'b0;
                wait_cnt   = 0;
            end
        end
    end

    // Monitor: every accepted head must match the scoreboard front.
    always @(negedge clk) begin
        if (!rst_i) begin
            stall_model = 0;
        end else begin
            if (!instr_valid_o && start_i) begin
                stall_model++;
            end
            if (instr_valid_o && instr_ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc 0x%08h instr 0x%08h, expected no output",
                             pc_o, instr_o);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("sb_pc", pc_o, exp_e[63:32]);
                    check("sb_instr", instr_o, exp_e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic wait_addr(input logic [31:0] a, input string name);
        int  n;
        logic found;
        n     = 0;
        found = 1'b0;
        while (!found && n < 80) begin
            tick();
            n++;
            found = imem_req_o && (imem_addr_o == a);
        end
        check(name, {31'b0, found}, 32'h1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || instr_valid_o) && n < 80) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        check({name, "_idle_req"}, {31'b0, imem_req_o}, 32'h0);
    endtask

    task automatic do_reset();
        rst_i         = 1'b0;
        start_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        @(negedge clk);
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i         = 1'b0;
        start_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        repeat (2) tick();
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b1;
        tick();

        // 1: zero-wait streaming, four fetches
        lat = 0;
        expect_out(32'h0000_0000, 32'hA5A5_0000);
        expect_out(32'h0000_0004, 32'hA5A5_0004);
        expect_out(32'h0000_0008, 32'hA5A5_0008);
        expect_out(32'h0000_000C, 32'hA5A5_000C);
        start_i = 1'b1;
        wait_addr(32'h0000_000C, "t1_reach_c");
        start_i = 1'b0;
        wait_drain("t1");
        check("t1_next_addr", imem_addr_o, 32'h0000_0010);

        // 2: stalled consumer fills the FIFO, then drains and fetch resumes at 0x10
        do_reset();
        lat           = 0;
        instr_ready_i = 1'b0;
        expect_out(32'h0000_0000, 32'hA5A5_0000);
        expect_out(32'h0000_0004, 32'hA5A5_0004);
        expect_out(32'h0000_0008, 32'hA5A5_0008);
        expect_out(32'h0000_000C, 32'hA5A5_000C);
        expect_out(32'h0000_0010, 32'hA5A5_0010);
        start_i = 1'b1;
        wait_addr(32'h0000_000C, "t2_reach_c");
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_full_no_req", {31'b0, imem_req_o}, 32'h0);
        end
        check("t2_full_valid", {31'b0, instr_valid_o}, 32'h1);
        check("t2_full_head_pc", pc_o, 32'h0000_0000);
        check("t2_full_addr", imem_addr_o, 32'h0000_0010);
        instr_ready_i = 1'b1;
        tick();
        check("t2_resume_req", {31'b0, imem_req_o}, 32'h1);
        check("t2_resume_addr", imem_addr_o, 32'h0000_0010);
        start_i = 1'b0;
        wait_drain("t2");

        // 3: 3-cycle memory, flush while 0x8 is outstanding
        do_reset();
        lat = 3;
        expect_out(32'h0000_0000, 32'hA5A5_0000);
        start_i = 1'b1;
        wait_addr(32'h0000_0008, "t3_reach_8");
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        exp_q.delete();
        expect_out(32'h0000_0100, 32'hA5A5_0100);
        tick();
        flush_i = 1'b0;
        check("t3_flush_valid", {31'b0, instr_valid_o}, 32'h0);
        check("t3_drain_req", {31'b0, imem_req_o}, 32'h1);
        check("t3_drain_addr", imem_addr_o, 32'h0000_0008);
        wait_addr(32'h0000_0100, "t3_reach_100");
        start_i = 1'b0;
        wait_drain("t3");
`ifdef FETCH_PERF_CNT_EN
        check("t6_fetch_cnt", fetch_cnt_o, 32'd3);
        check("t6_stall_cnt", stall_cnt_o, stall_model);
`endif

        // 4: flush coincides with ack and pop
        do_reset();
        lat = 0;
        expect_out(32'h0000_0000, 32'hA5A5_0000);
        start_i = 1'b1;
        wait_addr(32'h0000_0008, "t4_reach_8");
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_0040;
        exp_q.delete();
        expect_out(32'h0000_0040, 32'hA5A5_0040);
        tick();
        flush_i = 1'b0;
        check("t4_valid", {31'b0, instr_valid_o}, 32'h0);
        check("t4_req", {31'b0, imem_req_o}, 32'h0);
        check("t4_addr", imem_addr_o, 32'h0000_0040);
        wait_addr(32'h0000_0040, "t4_reach_40");
        start_i = 1'b0;
        wait_drain("t4");

        // 5: asynchronous reset in the middle of a request
        do_reset();
        lat           = 3;
        instr_ready_i = 1'b0;
        start_i       = 1'b1;
        wait_addr(32'h0000_0004, "t5_reach_4");
        check("t5_pre_valid", {31'b0, instr_valid_o}, 32'h1);
        #2;
        rst_i = 1'b0;
        exp_q.delete();
        #1;
        check("t5_async_req", {31'b0, imem_req_o}, 32'h0);
        check("t5_async_valid", {31'b0, instr_valid_o}, 32'h0);
        check("t5_async_addr", imem_addr_o, 32'h0000_0000);
        check("t5_async_pc", pc_o, 32'h0);
        start_i       = 1'b0;
        instr_ready_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b1;
        tick();
        expect_out(32'h0000_0000, 32'hA5A5_0000);
        start_i = 1'b1;
        begin
            int n;
            n = 0;
            while (!imem_req_o && n < 20) begin
                tick();
                n++;
            end
        end
        start_i = 1'b0;
        check("t5_restart_req", {31'b0, imem_req_o}, 32'h1);
        check("t5_restart_addr", imem_addr_o, 32'h0000_0000);
        wait_drain("t5");

        // 7: redirect alignment and PC wrap past 0xFFFF_FFFC
        do_reset();
        lat           = 0;
        flush_i       = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        flush_i = 1'b0;
        check("t7_align", imem_addr_o, 32'hFFFF_FFFC);
        expect_out(32'hFFFF_FFFC, 32'h5A5A_FFFC);
        expect_out(32'h0000_0000, 32'hA5A5_0000);
        start_i = 1'b1;
        wait_addr(32'hFFFF_FFFC, "t7_reach_top");
        wait_addr(32'h0000_0000, "t7_reach_wrap");
        start_i = 1'b0;
        wait_drain("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
